// File: rtl/drum_step_sequencer.sv
// Drum step sequencer: 16x4 pattern, tick-based tempo, live pads, quantized record, idle edit.
// Optional macro SWING_EN delays odd steps by min(swing, len_q-1) ticks.
module drum_step_sequencer #(
  parameter int STEPS  = 16,
  parameter int TRACKS = 4,
  parameter int LEN_W  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       play,
  input  logic                       stop,
  input  logic                       rec_en,
  input  logic [TRACKS-1:0]          pad,
  input  logic                       advance,
  input  logic                       clear,
  input  logic [LEN_W-1:0]           step_len,
  input  logic [3:0]                 swing,
  output logic [TRACKS-1:0]          trig,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       running,
  output logic                       beat
);

  localparam int IDX_W = $clog2(STEPS);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t state, state_nxt;

  logic [TRACKS-1:0] pattern [STEPS];
  logic [TRACKS-1:0] pat_nxt [STEPS];
  logic [LEN_W-1:0]  tcnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_eff;
  logic              halt;
  logic              run_tick;
  logic              boundary;
  logic              arm_fire;
  logic              fire_now;
  logic [IDX_W-1:0]  idx_inc;
  logic [IDX_W-1:0]  fire_idx;
  logic              rec_on;
  logic              in_window;
  logic [TRACKS-1:0] live;

  assign len_eff   = (step_len == '0) ? LEN_ONE : step_len;
  assign halt      = stop && (state != IDLE);
  assign run_tick  = (state == RUN) && tick && !stop;
  assign boundary  = run_tick && (tcnt == len_q - LEN_ONE);
  assign arm_fire  = (state == ARM) && tick && !stop;
  assign idx_inc   = step_idx + IDX_ONE;
  assign fire_idx  = boundary ? idx_inc : step_idx;

  // Pads in the second half of a step are pushed to the next step and stay silent now.
  assign rec_on    = (state == RUN) && rec_en;
  assign in_window = tcnt < (len_q >> 1);
  assign live      = (rec_on && !in_window) ? '0 : pad;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (play && !stop) state_nxt = ARM;
      ARM:     if (stop) state_nxt = IDLE;
               else if (tick) state_nxt = RUN;
      RUN:     if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pat_nxt = pattern;
    if (clear) begin
      pat_nxt = '{default: '0};
    end else if (state == IDLE) begin
      pat_nxt[step_idx] = pattern[step_idx] ^ pad;
    end else if (rec_on) begin
      if (in_window) pat_nxt[step_idx] = pattern[step_idx] | pad;
      else           pat_nxt[idx_inc]  = pattern[idx_inc] | pad;
    end
  end

`ifdef SWING_EN
  logic [3:0]       pend_cnt;
  logic [3:0]       pend_nxt;
  logic [3:0]       dly;
  logic [LEN_W-1:0] len_m1;

  assign len_m1 = len_eff - LEN_ONE;
  assign dly    = (len_m1 < LEN_W'(swing)) ? len_m1[3:0] : swing;

  // A swung odd step parks its fire in pend_cnt and counts down on run ticks.
  always_comb begin
    fire_now = 1'b0;
    pend_nxt = pend_cnt;
    if (halt) begin
      pend_nxt = '0;
    end else if ((arm_fire || boundary) && fire_idx[0] && (dly != '0)) begin
      pend_nxt = dly;
    end else if (arm_fire || boundary) begin
      fire_now = 1'b1;
    end else if (run_tick && (pend_cnt != '0)) begin
      pend_nxt = pend_cnt - 4'd1;
      fire_now = (pend_cnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_cnt <= '0;
    else     pend_cnt <= pend_nxt;
  end
`else
  logic unused_swing;
  assign unused_swing = ^swing;
  assign fire_now     = arm_fire || boundary;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern  <= '{default: '0};
      tcnt     <= '0;
      len_q    <= LEN_ONE;
      step_idx <= '0;
      trig     <= '0;
      beat     <= 1'b0;
      running  <= 1'b0;
    end else begin
      pattern <= pat_nxt;
      trig    <= (fire_now ? pat_nxt[fire_idx] : '0) | live;
      beat    <= fire_now && (fire_idx == '0);
      running <= (state_nxt == RUN);
      if (halt) begin
        tcnt     <= '0;
        step_idx <= '0;
      end else if (arm_fire) begin
        tcnt  <= '0;
        len_q <= len_eff;
      end else if (boundary) begin
        tcnt     <= '0;
        step_idx <= idx_inc;
        len_q    <= len_eff;
      end else if (run_tick) begin
        tcnt <= tcnt + LEN_ONE;
      end else if ((state == IDLE) && advance) begin
        step_idx <= idx_inc;
      end
    end
  end

endmodule

// File: doc/drum_step_sequencer.md
# drum_step_sequencer

Step sequencer and trigger scheduler for the drum-sample playback path. Holds a 16-step × 4-track pattern and counts 8 kHz sample-read strobes to set the tempo. At each step boundary it issues one-cycle trigger pulses that restart the clap/hihat/kick/snare sample readers. It also supports live pad play, quantized pattern recording, and idle-mode step editing.

## Interface
- STEPS, 16, steps per pattern (power of two)
- TRACKS, 4, voices; bit 0 clap, 1 hihat, 2 kick, 3 snare
- LEN_W, 12, width of step length in ticks
- clk  in  1  system clock (2 MHz domain)
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle 8 kHz strobe from the sample-read clock divider
- play  in  1  one-cycle start pulse
- stop  in  1  one-cycle stop pulse
- rec_en  in  1  level; record pads into the pattern while running
- pad  in  TRACKS  one-cycle pad pulses; already debounced and edge-detected
- advance  in  1  one-cycle pulse; moves the edit cursor while idle
- clear  in  1  one-cycle pulse; erases the whole pattern
- step_len  in  LEN_W  ticks per step; 0 is treated as 1
- swing  in  4  swing delay in ticks (see Configuration)
- trig  out  TRACKS  registered one-cycle trigger per voice
- step_idx  out  $clog2(STEPS)  current playback step or edit cursor
- running  out  1  high in RUN
- beat  out  1  one-cycle pulse when step 0 fires

## Operation
- FSM states: IDLE, ARM, RUN.
  - IDLE → ARM on play.
  - ARM → RUN on the next tick. That tick fires the current step_idx (normally 0).
  - ARM or RUN → IDLE on stop. step_idx returns to 0.
  - play and stop in the same cycle: stop wins.
- Tick counter tcnt (LEN_W bits) counts only in RUN and only on tick.
  - Range 0..L-1, where L = max(step_len, 1).
  - L is latched into len_q when a step fires; mid-step changes to step_len take effect at the next boundary.
- Step boundary: in RUN, a tick with tcnt == len_q-1 sets tcnt to 0, increments step_idx modulo STEPS (STEPS-1 wraps to 0), and fires the new step.
- Firing step s: trig <= pattern[s] for that cycle. beat <= 1 when s == 0.
- Live play: any pad bit ORs into trig on the following cycle, except for a forward-quantized record (below).
- Recording (RUN and rec_en):
  - pad while tcnt < len_q/2 (integer shift): set pattern[step_idx] bits, with live trig.
  - Otherwise: set pattern[(step_idx+1) mod STEPS] bits, with no live trig; the note plays at the boundary.
  - Recording only sets bits; it never clears them.
- Edit mode (IDLE):
  - pad toggles pattern[step_idx] bits and also live-triggers.
  - advance increments step_idx with wrap.
  - advance is ignored outside IDLE.
- clear zeroes all pattern bits in any state. clear beats a same-cycle pad write.
- Pattern storage is STEPS×TRACKS flops, with no RAM inference required.

## Timing
- Reset values: state IDLE, pattern all 0, tcnt 0, len_q 1, step_idx 0, trig 0, running 0, beat 0.
- Reset mid-RUN: all of the above on the next edge. Pending triggers are dropped.
- Latency:
  - tick that fires a step → trig/beat high exactly 1 clk later, for 1 clk.
  - pad → live trig 1 clk later.
- running is asserted the cycle after the ARM → RUN transition. It deasserts the cycle after stop.
- A step boundary and a pad arriving in the same cycle: the pad is classified against the pre-boundary tcnt and step_idx.
- Outputs depend only on registers; no combinational path from any input to any output.

## Configuration
- SWING_EN defined:
  - Steps with an odd index fire D = min(swing, len_q-1) ticks after their boundary instead of at it. A pending-fire counter holds the delay.
  - D = 0 fires at the boundary.
  - stop or rst cancels a pending swung fire.
  - Quantization is unchanged.
- SWING_EN undefined:
  - The swing port is present but ignored.
  - All steps fire at their boundary; no pending-fire logic is built.

## Test plan
- Reset, then program pads 4'b0100 at steps 0, 4, 8, 12 in IDLE using advance; step_len = 2, play → kick trig every 8 ticks, first one 1 clk after the first tick following play; beat on steps 0 only.
- Running, step_len = 10, rec_en = 1, pad 4'b0001 at tcnt = 3 of step 5 → immediate trig 4'b0001; bit set in step 5. Pad at tcnt = 7 → no immediate trig; clap fires at step 6 boundary.
- step_len = 0 → one step per tick; step_idx wraps 15 → 0 with beat pulse.
- play and stop same cycle while IDLE → stays IDLE, running 0. stop mid-RUN → step_idx 0, no further trig.
- clear and pad same cycle in IDLE → pattern all 0, live trig still issued.
- SWING_EN, step_len = 8, swing = 3, pattern all 1s → even steps fire at the boundary, odd steps 3 ticks later. swing = 15 clamps to 7 ticks.
